// File: rtl/fpu_pkg.sv
// fpu_pkg: opcode/state enums, unit indices and the quiet-NaN word shared by the dispatcher
package fpu_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_PASSA, OP_PASSB} op_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PUSH} state_t;
  localparam int U_ADD = 0;
  localparam int U_MUL = 1;
  localparam int U_DIV = 2;
  localparam logic [31:0] QNAN32 = 32'h7FC00000;
  function automatic logic [1:0] unit_of(input logic [2:0] op);
    return op == OP_MUL ? 2'(U_MUL) : op == OP_DIV ? 2'(U_DIV) : 2'(U_ADD);
  endfunction
endpackage

// File: rtl/fpu_dispatch_if.sv
// fpu_dispatch_if: command, unit-issue and result channels of the dispatcher
interface fpu_dispatch_if #(parameter int W = 32);
  logic cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [W-1:0] cmd_a, cmd_b, unit_a, unit_b;
  logic unit_sub;
  logic [2:0] unit_start, unit_done;
  logic [3*W-1:0] unit_result;
  logic res_valid, res_ready, res_err, busy;
  logic [W-1:0] res_data;
  modport master(input cmd_valid, cmd_op, cmd_a, cmd_b, unit_done, unit_result, res_ready,
                 output cmd_ready, unit_a, unit_b, unit_sub, unit_start, res_valid, res_data, res_err, busy);
  modport slave(output cmd_valid, cmd_op, cmd_a, cmd_b, unit_done, unit_result, res_ready,
                input cmd_ready, unit_a, unit_b, unit_sub, unit_start, res_valid, res_data, res_err, busy);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; head reads as zero while empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count[AW];
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: buffers FP commands, issues them one at a time to the units, queues results in order
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int W = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT = 1024,
  parameter logic [W-1:0] NAN_VAL = QNAN32
) (
  input logic clk,
  input logic rst,
  fpu_dispatch_if.master bus
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  state_t state, state_d;
  logic [2:0] op_q, op_d, start;
  logic [W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic err_q, err_d, cmd_full, cmd_empty, cmd_pop, res_full, res_empty, res_push;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [1:0] sel;
  logic [2*W+2:0] cmd_dout;
  logic [W:0] res_dout;
  logic [$clog2(CMD_DEPTH):0] cmd_count;
  logic [$clog2(RES_DEPTH):0] res_count;
  sync_fifo #(.WIDTH(2*W+3), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk(clk), .rst(rst), .push(bus.cmd_valid && !cmd_full), .pop(cmd_pop),
    .din({bus.cmd_op, bus.cmd_a, bus.cmd_b}), .dout(cmd_dout),
    .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
  );
  sync_fifo #(.WIDTH(W+1), .DEPTH(RES_DEPTH)) u_res (
    .clk(clk), .rst(rst), .push(res_push), .pop(bus.res_valid && bus.res_ready),
    .din({err_q, data_q}), .dout(res_dout),
    .full(res_full), .empty(res_empty), .count(res_count)
  );
  assign sel = unit_of(op_q);
  assign bus.cmd_ready = !cmd_full;
  assign bus.res_valid = !res_empty;
  assign {bus.res_err, bus.res_data} = res_dout;
  assign bus.unit_a = a_q;
  assign bus.unit_b = b_q;
  assign bus.unit_sub = op_q == OP_SUB;
  assign bus.unit_start = rst ? 3'b000 : start;
  assign bus.busy = state != S_IDLE || |cmd_count || |res_count;
  always_comb begin
    state_d = state;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    err_d = err_q;
    tcnt_d = tcnt;
    cmd_pop = 1'b0;
    res_push = 1'b0;
    start = 3'b000;
    case (state)
      S_IDLE: if (!cmd_empty && !res_full) begin
        cmd_pop = 1'b1;
        {op_d, a_d, b_d} = cmd_dout;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        tcnt_d = '0;
        state_d = op_q[2] ? S_PUSH : S_WAIT;
        start = op_q[2] ? 3'b000 : 3'b001 << sel;
        data_d = !op_q[2] ? data_q : op_q[1] ? NAN_VAL : op_q[0] ? b_q : a_q;
        err_d = op_q[2] && op_q[1];
      end
      S_WAIT: begin
        // done wins over a timeout landing on the same cycle
        if (bus.unit_done[sel]) begin
          data_d = bus.unit_result[sel*W +: W];
          err_d = 1'b0;
          state_d = S_PUSH;
        end else if (tcnt == TMAX) begin
          data_d = NAN_VAL;
          err_d = 1'b1;
          state_d = S_PUSH;
        end else tcnt_d = tcnt + 1'b1;
      end
      S_PUSH: begin
        res_push = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      tcnt <= '0;
    end else begin
      state <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      err_q <= err_d;
      tcnt <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: scoreboard bench with stub FP units and a randomized command stream
module tb_fpu_dispatch;
  import fpu_pkg::*;
  localparam int W = 32;
  localparam int TO = 16;
  typedef struct {int unit; int dly; logic [31:0] res; logic [31:0] a; logic [31:0] b; logic sub;} job_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  fpu_dispatch_if #(.W(W)) bus();
  fpu_dispatch #(.W(W), .CMD_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(TO), .NAN_VAL(QNAN32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  job_t job_q[$];
  job_t j;
  logic [32:0] exp_q[$];
  logic [32:0] res_e;
  int tests = 0, fails = 0, pops = 0, start_cyc = 0;
  int n, s0, p0, cur_dly, d;
  logic [31:0] cur_res;
  logic [2:0] op;
  bit saw_full = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // dly 0 means the stub never answers; dly beyond TO answers only after the timeout
  function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] r, input int dl);
    if (o == 3'd4) return {1'b0, a};
    if (o == 3'd5) return {1'b0, b};
    if (o >= 3'd6) return {1'b1, QNAN32};
    return (dl >= 1 && dl <= TO) ? {1'b0, r} : {1'b1, QNAN32};
  endfunction

  always @(negedge clk) if (!rst && bus.cmd_valid && bus.cmd_ready) begin
    exp_q.push_back(model(bus.cmd_op, bus.cmd_a, bus.cmd_b, cur_res, cur_dly));
    if (bus.cmd_op < 3'd4)
      job_q.push_back('{bus.cmd_op == 3'd3 ? 2 : bus.cmd_op == 3'd2 ? 1 : 0, cur_dly, cur_res,
                        bus.cmd_a, bus.cmd_b, bus.cmd_op == 3'd1});
  end

  always @(negedge clk) if (!rst && bus.res_valid && bus.res_ready) begin
    pops++;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_result: got %h expected none", {bus.res_err, bus.res_data});
    end else begin
      res_e = exp_q.pop_front();
      chk("result", {bus.res_err, bus.res_data}, res_e);
    end
  end

  always @(negedge clk) if (!rst) begin
    if (bus.unit_start != 3'b000) begin
      start_cyc++;
      chk("start_onehot", 64'($onehot(bus.unit_start)), 1);
    end
    if (!bus.cmd_ready) saw_full = 1;
  end

  initial begin
    bus.unit_done = 3'b000;
    bus.unit_result = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.unit_start != 3'b000) begin
        if (job_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_start: got %b expected none", bus.unit_start);
        end else begin
          j = job_q.pop_front();
          chk("start_unit", 64'(bus.unit_start), 64'(3'b001 << j.unit));
          chk("unit_a", 64'(bus.unit_a), 64'(j.a));
          chk("unit_b", 64'(bus.unit_b), 64'(j.b));
          chk("unit_sub", 64'(bus.unit_sub), 64'(j.sub));
          if (j.dly > 0) begin
            repeat (j.dly) @(negedge clk);
            if (!rst) begin
              bus.unit_done = 3'b001 << j.unit;
              bus.unit_result[j.unit*W +: W] = j.res;
              @(negedge clk);
              bus.unit_done = 3'b000;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int dl, input logic [31:0] r);
    int k = 0;
    bus.cmd_valid = 1;
    bus.cmd_op = o;
    bus.cmd_a = a;
    bus.cmd_b = b;
    cur_dly = dl;
    cur_res = r;
    do begin @(negedge clk); k++; end while (!bus.cmd_ready && k < 5000);
    if (!bus.cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got cmd_ready=0 expected 1");
    end
    @(posedge clk); #1;
    bus.cmd_valid = 0;
  endtask

  task automatic wait_valid();
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.res_valid && n < 100);
  endtask

  task automatic drain();
    int k = 0;
    do begin @(posedge clk); #1; k++; end while ((exp_q.size() != 0 || bus.busy) && k < 5000);
    chk("drain_done", 64'(k < 5000), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    exp_q.delete();
    job_q.delete();
    @(negedge clk);
    chk("start_in_reset", 64'(bus.unit_start), 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 0;
    bus.cmd_op = 0;
    bus.cmd_a = 0;
    bus.cmd_b = 0;
    bus.res_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 1);
    chk("rst_res_valid", 64'(bus.res_valid), 0);
    chk("rst_res_data", 64'(bus.res_data), 0);
    chk("rst_res_err", 64'(bus.res_err), 0);
    chk("rst_unit_start", 64'(bus.unit_start), 0);
    chk("rst_unit_a", 64'(bus.unit_a), 0);
    chk("rst_unit_b", 64'(bus.unit_b), 0);
    chk("rst_unit_sub", 64'(bus.unit_sub), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    @(posedge clk); #1;
    bus.res_ready = 1;
    send(3'd4, 32'h3FC00000, 32'h12345678, 0, 0);
    wait_valid();
    chk("passa_latency", 64'(n), 3);
    drain();
    s0 = start_cyc;
    p0 = pops;
    send(3'd0, 32'h3FC00000, 32'h40100000, 5, 32'h40700000);
    wait_valid();
    chk("add_latency", 64'(n), 8);
    drain();
    chk("add_start_cycles", 64'(start_cyc - s0), 1);
    chk("add_pops", 64'(pops - p0), 1);
    bus.res_ready = 0;
    saw_full = 0;
    s0 = start_cyc;
    p0 = pops;
    send(3'd1, 32'h40000000, 32'h3F800000, 3, 32'h3F800000);
    send(3'd2, 32'h40000000, 32'h40400000, 4, 32'h40C00000);
    send(3'd3, 32'h40C00000, 32'h40000000, 2, 32'h40400000);
    send(3'd5, 32'h11111111, 32'h22222222, 0, 0);
    send(3'd6, 32'h33333333, 32'h44444444, 0, 0);
    send(3'd0, 32'h3F800000, 32'h3F800000, 6, 32'h40000000);
    repeat (100) @(posedge clk);
    #1;
    chk("burst_cmd_full_seen", 64'(saw_full), 1);
    chk("burst_starts_stalled", 64'(start_cyc - s0), 3);
    chk("burst_held", 64'(pops - p0), 0);
    chk("burst_res_valid", 64'(bus.res_valid), 1);
    bus.res_ready = 1;
    drain();
    chk("burst_pops", 64'(pops - p0), 6);
    p0 = pops;
    send(3'd3, 32'h40000000, 32'h00000000, 20, 32'hDEADBEEF);
    wait_valid();
    chk("timeout_latency", 64'(n), 19);
    repeat (30) @(posedge clk);
    #1;
    chk("timeout_pops", 64'(pops - p0), 1);
    chk("timeout_res_valid", 64'(bus.res_valid), 0);
    chk("timeout_busy", 64'(bus.busy), 0);
    p0 = pops;
    for (int i = 0; i < 50; i++) begin
      op = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      send(op, $urandom, $urandom, d, $urandom);
    end
    drain();
    chk("random_pops", 64'(pops - p0), 50);
    s0 = start_cyc;
    send(3'd2, 32'h40000000, 32'h40000000, 0, 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (start_cyc == s0 && n < 50);
    chk("mul_started", 64'(start_cyc - s0), 1);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("post_rst_busy", 64'(bus.busy), 0);
    chk("post_rst_res_valid", 64'(bus.res_valid), 0);
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    p0 = pops;
    send(3'd0, 32'h3F800000, 32'h40000000, 2, 32'h40400000);
    drain();
    chk("post_rst_pops", 64'(pops - p0), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fpu_dispatch.md
Name: fpu_dispatch

Overview:
Parametrised command dispatcher placed between the UART receiver and the FP arithmetic units (adder/subtractor, multiplier, divider). It buffers operand/opcode commands in a command FIFO and issues them one at a time to the selected unit via a start/done handshake. Each unit has a timeout, and completed results are buffered in a result FIFO drained by the UART transmitter through valid/ready. It replaces the fixed, divider-ready-gated result path with in-order, loss-free, error-flagged result delivery.

Parameters:
W, 32, operand/result width in bits.
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
RES_DEPTH, 4, result FIFO entries (power of 2, >=2).
TIMEOUT, 1024, max cycles in WAIT before an operation is aborted.
NAN_VAL, 32'h7FC00000, W-bit data word emitted for aborted or illegal operations.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  command FIFO not full.
cmd_op  in  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 pass A, 101 pass B, 11x illegal.
cmd_a  in  W  operand A.
cmd_b  in  W  operand B.
unit_a  out  W  latched operand A to all units.
unit_b  out  W  latched operand B to all units.
unit_sub  out  1  1 = subtract (adder unit only).
unit_start  out  3  one-hot single-cycle start pulse; bit0 add/sub, bit1 mul, bit2 div.
unit_done  in  3  per-unit completion pulse.
unit_result  in  3*W  per-unit result, slice i*W +: W.
res_valid  out  1  result FIFO not empty.
res_ready  in  1  consumer accepts the head entry.
res_data  out  W  head result.
res_err  out  1  head entry came from a timeout or an illegal opcode.
busy  out  1  FSM not in IDLE, or either FIFO non-empty.

Behaviour:
- Reset: both FIFOs are emptied and the FSM goes to IDLE. After reset: cmd_ready=1, res_valid=0, res_data=0, res_err=0, unit_start=0, unit_a=0, unit_b=0, unit_sub=0, busy=0, timeout counter=0.
- A command is accepted on an edge where cmd_valid&&cmd_ready. cmd_ready is !cmd_full only; it is not combinationally dependent on a same-cycle pop.
- The result FIFO is show-ahead: res_data and res_err reflect the head entry. A pop occurs when res_valid&&res_ready.
- Both FIFOs support simultaneous push and pop in the same cycle, including when full or empty. Pointers wrap modulo depth. Counts are log2(depth)+1 bits.
- At most one operation is outstanding. Results leave in command order.
- FSM:
  - IDLE: when the command FIFO is non-empty and res_count < RES_DEPTH, pop the head into the op/A/B registers, then go to ISSUE.
  - ISSUE: for opcodes 000-011, drive unit_start[sel]=1 for exactly this cycle, clear the timeout counter, then go to WAIT. For pass A/B, load that operand as the result with err=0, then go to PUSH. For illegal opcodes, load NAN_VAL with err=1, then go to PUSH.
  - WAIT: on unit_done[sel], capture unit_result[sel] with err=0, then go to PUSH. If the counter reaches TIMEOUT-1 without done, load NAN_VAL with err=1, then go to PUSH. The counter increments each WAIT cycle.
  - PUSH: write {err,data} into the result FIFO (space is guaranteed by the IDLE check), then go to IDLE.
- unit_done bits on non-selected units, or outside WAIT, are ignored. A late done after a timeout is discarded.
- Latency with both FIFOs empty:
  - Pass and illegal ops: command accepted at edge 0, res_valid=1 after edge 3.
  - Unit ops: unit_start is high in the cycle after edge 1. If done is sampled at edge k, res_valid=1 after edge k+1.
- unit_a, unit_b and unit_sub hold stable from ISSUE until the next pop.
- Reset asserted mid-operation aborts it immediately. Nothing is pushed, and no unit_start is issued in the reset cycle.

Decomposition:
- Package fpu_pkg holds:
  - the opcode enum (OP_ADD..OP_PASSB);
  - the dispatch state enum (S_IDLE, S_ISSUE, S_WAIT, S_PUSH);
  - unit index constants (U_ADD=0, U_MUL=1, U_DIV=2);
  - the default QNAN32 constant.
- Sub-module sync_fifo (params WIDTH, DEPTH; ports push/pop/full/empty/count) is instantiated twice: W+3+W bits for commands, W+1 bits for results.

Test Plan:
- Pass A, cmd_a=32'h3FC00000, res_ready=1 -> res_data=32'h3FC00000, res_err=0, res_valid rises exactly 3 edges after accept.
- Add A=32'h3FC00000 (1.5), B=32'h40100000 (2.25); stub adder returns 32'h40700000 with done 5 cycles after start -> unit_sub=0, one start pulse on bit0, res_data=32'h40700000.
- Burst of 6 commands (sub, mul, div, pass B, 3'b110, add) with res_ready=0 -> cmd_ready drops when the command FIFO is full, the FSM stalls once the result FIFO holds 4 entries; raising res_ready drains all 6 in order, and the 3'b110 entry reads 32'h7FC00000 with res_err=1.
- Div with the stub never asserting done, TIMEOUT=16 -> NAN_VAL with res_err=1 is pushed after 16 WAIT cycles; a done pulse injected afterwards produces no extra entry.
- Full/empty corner: hold cmd_valid=1 and res_ready=1 continuously for 50 random ops -> no loss or duplication, counts never exceed the depths, scoreboard order matches.
- Assert rst during WAIT of a mul -> after reset busy=0, res_valid=0, cmd_ready=1, and the next command completes normally.
